ahb_mbox_mnt: RTL and testbench

Synthesisable, parametrised successor to the testbench AHB write monitor. It sits passively on a CPU AHB-Lite master port and decodes writes to a mailbox window: a status/console word and a GPR dump area. Console characters go into a buffered FIFO; pass/fail marks are counted to a configurable threshold; GPR slots are captured for readback. Supports wait states, SEQ transfers and pipelined back-to-back writes.

---
 rtl/ahb_mbox_mnt.sv | 174 +++++++++++++++++
 tb/tb_ahb_mbox_mnt.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_mbox_mnt.sv
// Passive AHB-Lite write monitor for a test mailbox window.
// Decodes console characters into a small FIFO, counts pass/fail marks and
// captures a GPR dump area that can be read back by index.
module ahb_mbox_mnt #(
    parameter int          ADDR_W      = 32,
    parameter int          DATA_W      = 32,
    parameter logic [31:0] MBOX_BASE   = 32'h20007c50,
    parameter logic [31:0] GPR_OFS     = 32'h10,
    parameter int          GPR_NUM     = 16,
    parameter logic [31:0] FAIL_CODE   = 32'h1001,
    parameter logic [31:0] PASS_CODE   = 32'h2002,
    parameter int          MARK_REPEAT = 2,
    parameter int          CON_DEPTH   = 16
) (
    input  logic              sysclk,
    input  logic              sysrst,
    input  logic [1:0]        ahb_htrans,
    input  logic              ahb_hready,
    input  logic              ahb_hwrite,
    input  logic [ADDR_W-1:0] ahb_haddr,
    input  logic [DATA_W-1:0] ahb_hwdata,
    output logic              con_valid,
    output logic [7:0]        con_data,
    input  logic              con_ready,
    output logic              con_ovfl,
    output logic              test_pass,
    output logic              test_fail,
    output logic              gpr_done,
    input  logic [4:0]        gpr_rd_idx,
    output logic [31:0]       gpr_rd_data,
    output logic [15:0]       wr_cnt
);
    localparam int              WA_W      = ADDR_W - 2;
    localparam int              PTR_W     = $clog2(CON_DEPTH);
    localparam logic [ADDR_W-1:0] MBOX_ADDR = ADDR_W'(MBOX_BASE);
    localparam logic [ADDR_W-1:0] GPR_ADDR  = ADDR_W'(MBOX_BASE + GPR_OFS);
    localparam logic [WA_W-1:0] MBOX_WA   = MBOX_ADDR[ADDR_W-1:2];
    localparam logic [WA_W-1:0] GPR_WA    = GPR_ADDR[ADDR_W-1:2];
    localparam logic [3:0]      MARK_LAST = 4'(MARK_REPEAT - 1);
    localparam logic [PTR_W:0]  CON_FULL  = (PTR_W + 1)'(CON_DEPTH);

    // Byte lanes within a word play no part in the decode.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^ahb_haddr[1:0];

    // Pending address phase (word address only).
    logic            ap_valid_reg;
    logic [WA_W-1:0] ap_waddr_reg;
    logic            addr_accept;
    assign addr_accept = ahb_hwrite && (ahb_htrans == 2'b10 || ahb_htrans == 2'b11);

    // Capture each address phase completed by HREADY; wait states hold it.
    always_ff @(posedge sysclk or posedge sysrst) begin
        if (sysrst) begin
            ap_valid_reg <= 1'b0;
            ap_waddr_reg <= '0;
        end else if (ahb_hready) begin
            ap_valid_reg <= addr_accept;
            ap_waddr_reg <= ahb_haddr[ADDR_W-1:2];
        end
    end

    // Data-phase decode.
    logic            data_smp, mbox_hit, gpr_hit, is_fail, is_pass;
    logic            fail_mark, pass_mark, con_push_req, flag_any;
    logic [WA_W-1:0] gpr_wofs;
    logic [4:0]      gpr_idx;

    // Classify the write whose data is on the bus this cycle.
    always_comb begin
        data_smp     = ahb_hready && ap_valid_reg;
        gpr_wofs     = ap_waddr_reg - GPR_WA;
        gpr_idx      = gpr_wofs[4:0];
        mbox_hit     = data_smp && (ap_waddr_reg == MBOX_WA);
        gpr_hit      = data_smp && (gpr_wofs < WA_W'(GPR_NUM));
        is_fail      = (ahb_hwdata == DATA_W'(FAIL_CODE));
        is_pass      = (ahb_hwdata == DATA_W'(PASS_CODE));
        fail_mark    = mbox_hit && is_fail;
        pass_mark    = mbox_hit && is_pass;
        con_push_req = mbox_hit && !is_fail && !is_pass;
        flag_any     = test_pass || test_fail;
    end

    // Mark counters; whichever flag rises first freezes both counters.
    logic [3:0] fail_cnt_reg, pass_cnt_reg;
    always_ff @(posedge sysclk or posedge sysrst) begin
        if (sysrst) begin
            fail_cnt_reg <= '0;
            pass_cnt_reg <= '0;
            test_fail    <= 1'b0;
            test_pass    <= 1'b0;
        end else if (!flag_any) begin
            if (fail_mark && fail_cnt_reg != 4'hF) begin
                fail_cnt_reg <= fail_cnt_reg + 4'd1;
                if (fail_cnt_reg == MARK_LAST) test_fail <= 1'b1;
            end
            if (pass_mark && pass_cnt_reg != 4'hF) begin
                pass_cnt_reg <= pass_cnt_reg + 4'd1;
                if (pass_cnt_reg == MARK_LAST) test_pass <= 1'b1;
            end
        end
    end

    // Window write counter and sticky end-of-dump flag.
    always_ff @(posedge sysclk or posedge sysrst) begin
        if (sysrst) begin
            wr_cnt   <= '0;
            gpr_done <= 1'b0;
        end else begin
            if (mbox_hit || gpr_hit) wr_cnt <= wr_cnt + 16'd1;
            if (gpr_hit && gpr_idx == 5'(GPR_NUM - 1)) gpr_done <= 1'b1;
        end
    end

    // GPR slots, padded to the full 32-entry readback index space with zeros.
    logic [31:0] gpr_pad [32];
    for (genvar gi = 0; gi < 32; gi++) begin : g_gpr
        if (gi < GPR_NUM) begin : g_slot
            logic [31:0] slot_reg;
            // Capture this slot when its word address is written.
            always_ff @(posedge sysclk or posedge sysrst) begin
                if (sysrst) slot_reg <= '0;
                else if (gpr_hit && gpr_idx == 5'(gi)) slot_reg <= ahb_hwdata[31:0];
            end
            assign gpr_pad[gi] = slot_reg;
        end else begin : g_none
            assign gpr_pad[gi] = '0;
        end
    end
    assign gpr_rd_data = gpr_pad[gpr_rd_idx];

    // Console FIFO.
    logic [7:0]       con_mem [CON_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [PTR_W:0]   cnt_reg, cnt_left, cnt_next;
    logic             con_pop, con_push, con_drop;

    // Pop/push arbitration: a pop in the same cycle frees room for a push on full.
    always_comb begin
        con_pop     = (cnt_reg != '0) && con_ready;
        con_push    = con_push_req && ((cnt_reg != CON_FULL) || con_pop);
        con_drop    = con_push_req && (cnt_reg == CON_FULL) && !con_pop;
        rd_ptr_next = rd_ptr_reg + PTR_W'(con_pop);
        cnt_left    = cnt_reg - (PTR_W + 1)'(con_pop);
        cnt_next    = cnt_left + (PTR_W + 1)'(con_push);
    end

    // Character storage, written without reset so it maps onto RAM.
    always_ff @(posedge sysclk) begin
        if (con_push) con_mem[wr_ptr_reg] <= ahb_hwdata[7:0];
    end

    // Pointers, fill level, registered head and sticky overflow.
    always_ff @(posedge sysclk or posedge sysrst) begin
        if (sysrst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            cnt_reg    <= '0;
            con_data   <= '0;
            con_ovfl   <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(con_push);
            rd_ptr_reg <= rd_ptr_next;
            cnt_reg    <= cnt_next;
            // When the FIFO drains to the incoming char, bypass it into the head.
            if (cnt_left == '0) con_data <= con_push ? ahb_hwdata[7:0] : 8'h00;
            else                con_data <= con_mem[rd_ptr_next];
            if (con_drop) con_ovfl <= 1'b1;
        end
    end

    assign con_valid = (cnt_reg != '0);

endmodule

// File: tb/tb_ahb_mbox_mnt.sv
// Self-checking bench for ahb_mbox_mnt: directed scenarios followed by
// randomized bus traffic, all checked against a transaction-level model.
module tb_ahb_mbox_mnt;
    localparam logic [31:0] BASE  = 32'h20007c50;
    localparam logic [31:0] GBASE = 32'h20007c60;

    logic        sysclk = 1'b0;
    logic        sysrst;
    logic [1:0]  ahb_htrans;
    logic        ahb_hready;
    logic        ahb_hwrite;
    logic [31:0] ahb_haddr;
    logic [31:0] ahb_hwdata;
    logic        con_valid;
    logic [7:0]  con_data;
    logic        con_ready;
    logic        con_ovfl;
    logic        test_pass;
    logic        test_fail;
    logic        gpr_done;
    logic [4:0]  gpr_rd_idx;
    logic [31:0] gpr_rd_data;
    logic [15:0] wr_cnt;

    ahb_mbox_mnt dut (
        .sysclk      (sysclk),
        .sysrst      (sysrst),
        .ahb_htrans  (ahb_htrans),
        .ahb_hready  (ahb_hready),
        .ahb_hwrite  (ahb_hwrite),
        .ahb_haddr   (ahb_haddr),
        .ahb_hwdata  (ahb_hwdata),
        .con_valid   (con_valid),
        .con_data    (con_data),
        .con_ready   (con_ready),
        .con_ovfl    (con_ovfl),
        .test_pass   (test_pass),
        .test_fail   (test_fail),
        .gpr_done    (gpr_done),
        .gpr_rd_idx  (gpr_rd_idx),
        .gpr_rd_data (gpr_rd_data),
        .wr_cnt      (wr_cnt)
    );

    always #5 sysclk = ~sysclk;

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model state.
    logic [7:0]  mq[$];
    int          m_pcnt, m_fcnt;
    bit          m_pass, m_fail, m_done, m_ovfl;
    logic [31:0] m_gpr [16];
    logic [15:0] m_wrcnt;
    bit          pend_v;
    logic [31:0] pend_a;
    bit          ready_drv, pop_with_data;
    logic [31:0] wa [32];
    logic [31:0] wd [32];

    task automatic model_reset();
        mq.delete();
        m_pcnt = 0; m_fcnt = 0;
        m_pass = 0; m_fail = 0; m_done = 0; m_ovfl = 0;
        m_wrcnt = '0;
        pend_v = 0; pend_a = '0;
        for (int i = 0; i < 16; i++) m_gpr[i] = '0;
    endtask

    // Effect of one completed write (any pop this edge already applied).
    task automatic model_write(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] off;
        off = (addr >> 2) - (GBASE >> 2);
        if ((addr >> 2) == (BASE >> 2)) begin
            m_wrcnt++;
            if (data == 32'h1001) begin
                if (!m_pass && !m_fail) begin
                    m_fcnt++;
                    if (m_fcnt >= 2) m_fail = 1;
                end
            end else if (data == 32'h2002) begin
                if (!m_pass && !m_fail) begin
                    m_pcnt++;
                    if (m_pcnt >= 2) m_pass = 1;
                end
            end else if (mq.size() < 16) begin
                mq.push_back(data[7:0]);
            end else begin
                m_ovfl = 1;
            end
            $display("txn mbox addr=%08h data=%08h", addr, data);
        end else if (off < 16) begin
            m_wrcnt++;
            m_gpr[off] = data;
            if (off == 15) m_done = 1;
            $display("txn gpr  addr=%08h data=%08h", addr, data);
        end
    endtask

    // One bus cycle: inputs already at negedge, model stepped at the posedge.
    task automatic bus(input logic [1:0] tr, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic rdy);
        ahb_htrans = tr;
        ahb_hwrite = wr;
        ahb_haddr  = addr;
        ahb_hwdata = wdata;
        ahb_hready = rdy;
        con_ready  = ready_drv | (pop_with_data & rdy & pend_v);
        @(posedge sysclk);
        if (con_ready && mq.size() > 0) void'(mq.pop_front());
        if (rdy && pend_v) model_write(pend_a, wdata);
        if (rdy) begin
            pend_v = wr && tr[1];
            pend_a = addr;
        end
        @(negedge sysclk);
    endtask

    // Pipelined burst of n writes from wa/wd, optional wait states per data phase.
    task automatic wr_burst(input int n, input bit seq, input int waits);
        logic [1:0]  tr;
        logic [31:0] a, d;
        for (int k = 0; k <= n; k++) begin
            tr = (k < n) ? ((seq && k > 0) ? 2'b11 : 2'b10) : 2'b00;
            a  = (k < n) ? wa[k] : 32'h0;
            d  = (k > 0) ? wd[k-1] : $urandom;
            if (k > 0) for (int w = 0; w < waits; w++) bus(tr, 1'b1, a, d, 1'b0);
            bus(tr, 1'b1, a, d, 1'b1);
        end
    endtask

    task automatic wr1(input logic [31:0] a, input logic [31:0] d, input int waits);
        wa[0] = a;
        wd[0] = d;
        wr_burst(1, 1'b0, waits);
    endtask

    task automatic check_outputs();
        check_val("con_valid", con_valid, (mq.size() > 0));
        if (mq.size() > 0) check_val("con_data", con_data, mq[0]);
        check_val("con_ovfl", con_ovfl, m_ovfl);
        check_val("test_pass", test_pass, m_pass);
        check_val("test_fail", test_fail, m_fail);
        check_val("gpr_done", gpr_done, m_done);
        check_val("wr_cnt", wr_cnt, m_wrcnt);
    endtask

    task automatic check_gpr(input int idx);
        gpr_rd_idx = 5'(idx);
        #1;
        check_val("gpr_rd_data", gpr_rd_data, (idx < 16) ? m_gpr[idx] : 32'h0);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
    task automatic do_reset();
        sysrst = 1'b1;
        #1;
        model_reset();
        check_val("rst_con_valid", con_valid, 0);
        check_val("rst_con_data", con_data, 0);
        check_val("rst_ovfl", con_ovfl, 0);
        check_val("rst_pass", test_pass, 0);
        check_val("rst_fail", test_fail, 0);
        check_val("rst_done", gpr_done, 0);
        check_val("rst_wr_cnt", wr_cnt, 0);
        check_gpr(15);
        @(negedge sysclk);
        sysrst = 1'b0;
    endtask

    initial begin
        ahb_htrans = 2'b00; ahb_hwrite = 0; ahb_haddr = '0; ahb_hwdata = '0;
        ahb_hready = 1; con_ready = 0; gpr_rd_idx = '0;
        ready_drv = 0; pop_with_data = 0;
        sysrst = 1'b0;
        model_reset();
        @(negedge sysclk);
        do_reset();

        // Two console characters, then two pops.
        wr1(BASE, 32'h48, 0);
        wr1(BASE, 32'h69, 0);
        check_outputs();
        check_val("t1_valid", con_valid, 1);
        check_val("t1_data", con_data, 8'h48);
        check_val("t1_wrcnt", wr_cnt, 16'd2);
        ready_drv = 1;
        bus(2'b00, 1'b0, 32'h0, 32'h0, 1'b1);
        check_val("t1_pop1", con_data, 8'h69);
        check_outputs();
        bus(2'b00, 1'b0, 32'h0, 32'h0, 1'b1);
        check_val("t1_empty", con_valid, 0);
        ready_drv = 0;

        // Pass marks, second with a wait state; later fail marks are ignored.
        wr1(BASE, 32'h2002, 0);
        check_val("t2_pass_once", test_pass, 0);
        wr1(BASE, 32'h2002, 1);
        check_val("t2_pass_twice", test_pass, 1);
        wr1(BASE, 32'h1001, 0);
        wr1(BASE, 32'h1001, 2);
        check_val("t2_fail_frozen", test_fail, 0);
        check_outputs();

        // SEQ burst into all GPR slots.
        for (int i = 0; i < 16; i++) begin
            wa[i] = GBASE + 32'(4 * i);
            wd[i] = 32'h11110000 + 32'(i);
        end
        wr_burst(16, 1'b1, 0);
        check_val("t3_done", gpr_done, 1);
        check_gpr(5);
        check_val("t3_gpr5", gpr_rd_data, 32'h11110005);
        check_gpr(20);
        check_val("t3_gpr20", gpr_rd_data, 32'h0);
        check_outputs();

        // Overflow: 17 chars into depth 16, then push on full with a pop.
        for (int i = 0; i < 17; i++) begin
            wa[i] = BASE;
            wd[i] = 32'h61 + 32'(i);
        end
        wr_burst(17, 1'b0, 0);
        check_val("t4_ovfl", con_ovfl, 1);
        check_val("t4_head", con_data, 8'h61);
        check_outputs();
        pop_with_data = 1;
        wr1(BASE, 32'h7a, 0);
        pop_with_data = 0;
        check_val("t4_head2", con_data, 8'h62);
        check_outputs();
        ready_drv = 1;
        for (int i = 0; i < 18; i++) begin
            bus(2'b00, 1'b0, 32'h0, 32'h0, 1'b1);
            check_outputs();
        end
        ready_drv = 0;

        // Back-to-back NONSEQ, then a read and IDLE/BUSY writes that must be ignored.
        wa[0] = BASE; wd[0] = 32'h41;
        wa[1] = BASE; wd[1] = 32'h42;
        wr_burst(2, 1'b0, 0);
        check_val("t5_head", con_data, 8'h41);
        bus(2'b10, 1'b0, BASE, 32'h0, 1'b1);
        bus(2'b00, 1'b1, BASE, 32'h55, 1'b1);
        bus(2'b01, 1'b1, BASE, 32'h56, 1'b1);
        bus(2'b00, 1'b0, 32'h0, 32'h57, 1'b1);
        check_outputs();
        ready_drv = 1;
        bus(2'b00, 1'b0, 32'h0, 32'h0, 1'b1);
        check_val("t5_second", con_data, 8'h42);
        bus(2'b00, 1'b0, 32'h0, 32'h0, 1'b1);
        check_outputs();
        ready_drv = 0;

        // Reset between address and data phase of a pass mark.
        bus(2'b10, 1'b1, BASE, 32'h0, 1'b1);
        do_reset();
        bus(2'b00, 1'b0, 32'h0, 32'h2002, 1'b1);
        check_val("t6_wrcnt", wr_cnt, 0);
        check_outputs();

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            logic [1:0]  tr;
            logic        wr, rdy;
            logic [31:0] a, d;
            rdy = ($urandom_range(0, 3) != 0);
            tr  = 2'($urandom_range(0, 3));
            wr  = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 5))
                0:       a = BASE;
                1:       a = BASE + 32'($urandom_range(0, 3));
                2:       a = GBASE + 32'(4 * $urandom_range(0, 15));
                3:       a = GBASE + 32'(4 * $urandom_range(16, 19));
                4:       a = BASE - 32'd4;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       d = 32'h2002;
                1:       d = 32'h1001;
                default: d = $urandom;
            endcase
            ready_drv = ($urandom_range(0, 2) == 0);
            bus(tr, wr, a, d, rdy);
            check_outputs();
            check_gpr($urandom_range(0, 31));
            if (c % 200 == 199) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
